xsw_switch_core: RTL and testbench
==================================

// Module: xsw_switch_core
// PURPOSE
//   Parametrised N-port crossbar switch core: the next-generation Xwitch datapath.
//   Each input port presents an (addr, data) word with a valid/accept handshake.
//   The word routes to the output port whose programmable address matches, with
//   per-output round-robin arbitration and a per-output FIFO with level flags.
//   Sits between the upstream driver-side interface and the downstream monitor-side interface.
// PARAMETERS
//   N_PORTS    8   number of input ports = number of output ports (2..16)
//   DATA_W     8   data bits per port
//   ADDR_W     8   address bits per port
//   FIFO_DEPTH 8   words per output FIFO (power of 2, >=4)
//   AE_LEVEL   1   fifo_ae asserted when count <= AE_LEVEL
//   AF_LEVEL   7   fifo_af asserted when count >= AF_LEVEL
// PORTS
//   clk        in   1                 clock, all state on rising edge
//   reset      in   1                 asynchronous, active-high reset
//   addr_in    in   N_PORTS*ADDR_W    destination address, slice i = input port i
//   data_in    in   N_PORTS*DATA_W    payload, slice i = input port i
//   wr_en      in   N_PORTS           valid per input port; held until data_rcv
//   data_rcv   out  N_PORTS           accept per input port (combinational)
//   addr_out   out  N_PORTS*ADDR_W    source port index of head word (zero-extended)
//   data_out   out  N_PORTS*DATA_W    head-of-FIFO payload per output port
//   data_rdy   out  N_PORTS           output FIFO i non-empty
//   rd_en      in   N_PORTS           pop request per output port
//   port_en    in   1                 config access strobe
//   port_wr    in   1                 1 = config write; 0 = no-op
//   port_sel   in   N_PORTS           one-hot/multi-hot output-port select for config write
//   port_addr  in   ADDR_W            address value to program
//   fifo_empty out  N_PORTS           count == 0
//   fifo_full  out  N_PORTS           count == FIFO_DEPTH
//   fifo_ae    out  N_PORTS           count <= AE_LEVEL
//   fifo_af    out  N_PORTS           count >= AF_LEVEL
//   drop_cnt   out  16                saturating count of unmatched (dropped) words
// BEHAVIOUR
// - Reset: FIFOs emptied; rr pointers 0; drop_cnt 0; port address reg i = i.
//   Outputs then: data_rdy 0, fifo_empty 1, fifo_full 0, fifo_ae 1, fifo_af 0, data_out/addr_out 0.
// - Config: port_en & port_wr at edge -> addr reg j <= port_addr for every j with port_sel[j].
//   New address takes effect the cycle after the write; words in flight are unaffected.
// - Match: input i targets lowest-index output j with addr reg j == addr_in slice i.
//   No match -> data_rcv[i]=1 same cycle, word discarded, drop_cnt +1 (saturates at 16'hFFFF).
//   If several inputs miss in one cycle, drop_cnt adds their count (saturating).
// - Arbitration per output j: requesters = inputs with wr_en & match j.
//   Grant = first requester at or after rr_ptr[j], cyclic. No grant while fifo_full[j],
//   even with a same-cycle pop; full blocks pushes.
//   On a grant, rr_ptr[j] <= granted+1 mod N_PORTS. With no grant, rr_ptr[j] holds.
// - data_rcv[i] = wr_en[i] & (granted | unmatched); purely combinational, no registered stall.
// - Push at edge on grant; word stored with source index i. data_rdy[j] is high from the next cycle (latency 1).
// - FIFO is show-ahead: data_out/addr_out show head whenever data_rdy; value undefined-held when empty (drive 0).
// - Pop: rd_en[j] & data_rdy[j] at edge. rd_en while empty is ignored, with no underflow.
// - Push+pop same cycle (not full): count unchanged, order preserved.
// - Pointers wrap modulo FIFO_DEPTH. Count has width clog2(FIFO_DEPTH)+1.
// - Flags are registered from count and valid the cycle after the push/pop edge.
// - Reset mid-operation: everything returns to reset state immediately (async); pending words are lost.
// TESTING
// - After reset, in0 sends addr=3,data=8'hA5 -> data_rcv[0]=1 same cycle; data_rdy[3]=1 next cycle,
//   data_out[3]=A5, addr_out[3]=0; rd_en[3] -> empty.
// - Inputs 1,2,5 all send to addr 4 for 6 cycles, held -> grants in order 1,2,5,1,2,5; FIFO4 data in that order.
// - Config write port_sel=0x01, port_addr=8'h40; in2 sends addr 0x40 -> lands in FIFO0.
//   addr 0x00 -> dropped, drop_cnt=1.
// - Fill FIFO6 with 8 words, no reads -> fifo_full[6]=1, fifo_af from count 7.
//   9th word: data_rcv held 0 until one rd_en, then accepted next cycle.
// - Simultaneous push+pop on FIFO2 at count 4 -> count stays 4, flags steady. rd_en on empty FIFO -> no change.
// - Assert reset mid-burst with 5 words queued -> all fifo_empty=1, drop_cnt=0, addr reg i=i restored.

Source files
------------

// File: rtl/xsw_switch_core.sv
// N-port crossbar: address-matched routing, per-output round-robin arbiter and
// show-ahead FIFO with registered level flags and a saturating drop counter.
module xsw_switch_core #(
    parameter int N_PORTS    = 8,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int AE_LEVEL   = 1,
    parameter int AF_LEVEL   = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PORTS*ADDR_W-1:0]   addr_in,
    input  logic [N_PORTS*DATA_W-1:0]   data_in,
    input  logic [N_PORTS-1:0]          wr_en,
    output logic [N_PORTS-1:0]          data_rcv,
    output logic [N_PORTS*ADDR_W-1:0]   addr_out,
    output logic [N_PORTS*DATA_W-1:0]   data_out,
    output logic [N_PORTS-1:0]          data_rdy,
    input  logic [N_PORTS-1:0]          rd_en,
    input  logic                        port_en,
    input  logic                        port_wr,
    input  logic [N_PORTS-1:0]          port_sel,
    input  logic [ADDR_W-1:0]           port_addr,
    output logic [N_PORTS-1:0]          fifo_empty,
    output logic [N_PORTS-1:0]          fifo_full,
    output logic [N_PORTS-1:0]          fifo_ae,
    output logic [N_PORTS-1:0]          fifo_af,
    output logic [15:0]                 drop_cnt
);
    localparam int SW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [N_PORTS-1:0][ADDR_W-1:0] paddr_q;
    logic [N_PORTS-1:0][SW-1:0]     rr_q, rr_d;
    logic [N_PORTS-1:0][PW-1:0]     wp_q, rp_q;
    logic [N_PORTS-1:0][CW-1:0]     cnt_q, cnt_d;
    logic [N_PORTS-1:0]             empty_q, full_q, ae_q, af_q;
    logic [15:0]                    drop_q, drop_d;
    logic [16:0]                    drop_sum;
    logic [DATA_W-1:0]              mem_data_q [N_PORTS][FIFO_DEPTH];
    logic [SW-1:0]                  mem_src_q  [N_PORTS][FIFO_DEPTH];

    logic [N_PORTS-1:0]               hit, gnt_vld, push, pop;
    logic [N_PORTS-1:0][SW-1:0]       tgt, gnt_idx;
    logic [N_PORTS-1:0][N_PORTS-1:0]  req;
    logic [4:0]                       miss_n;

    // Descending scan so the lowest-index matching output wins.
    always_comb begin
        hit    = '0;
        tgt    = '0;
        req    = '0;
        miss_n = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            for (int j = N_PORTS - 1; j >= 0; j--) begin
                if (paddr_q[j] == addr_in[i*ADDR_W +: ADDR_W]) begin
                    hit[i] = 1'b1;
                    tgt[i] = SW'(j);
                end
            end
            if (wr_en[i] && hit[i])  req[tgt[i]][i] = 1'b1;
            if (wr_en[i] && !hit[i]) miss_n = miss_n + 5'd1;
        end
    end

    always_comb begin
        gnt_vld = '0;
        gnt_idx = '0;
        rr_d    = rr_q;
        for (int j = 0; j < N_PORTS; j++) begin
            for (int k = 0; k < N_PORTS; k++) begin
                if (!gnt_vld[j] && (cnt_q[j] != CW'(FIFO_DEPTH)) &&
                    req[j][(int'(rr_q[j]) + k) % N_PORTS]) begin
                    gnt_vld[j] = 1'b1;
                    gnt_idx[j] = SW'((int'(rr_q[j]) + k) % N_PORTS);
                end
            end
            if (gnt_vld[j])
                rr_d[j] = (int'(gnt_idx[j]) == N_PORTS - 1) ? '0 : gnt_idx[j] + SW'(1);
        end
    end

    always_comb begin
        data_rcv = '0;
        for (int i = 0; i < N_PORTS; i++)
            data_rcv[i] = wr_en[i] & (~hit[i] | (gnt_vld[tgt[i]] & (gnt_idx[tgt[i]] == SW'(i))));
    end

    always_comb begin
        push = gnt_vld;
        pop  = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            pop[j]   = rd_en[j] & (cnt_q[j] != '0);
            cnt_d[j] = cnt_q[j] + CW'(push[j]) - CW'(pop[j]);
        end
        drop_sum = {1'b0, drop_q} + 17'(miss_n);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < N_PORTS; j++) paddr_q[j] <= ADDR_W'(j);
            rr_q    <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            empty_q <= '1;
            full_q  <= '0;
            ae_q    <= '1;
            af_q    <= '0;
            drop_q  <= '0;
        end else begin
            for (int j = 0; j < N_PORTS; j++) begin
                if (port_en && port_wr && port_sel[j]) paddr_q[j] <= port_addr;
                if (push[j]) wp_q[j] <= wp_q[j] + PW'(1);
                if (pop[j])  rp_q[j] <= rp_q[j] + PW'(1);
                empty_q[j] <= (cnt_d[j] == '0);
                full_q[j]  <= (cnt_d[j] == CW'(FIFO_DEPTH));
                ae_q[j]    <= (cnt_d[j] <= CW'(AE_LEVEL));
                af_q[j]    <= (cnt_d[j] >= CW'(AF_LEVEL));
            end
            rr_q   <= rr_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    // Storage needs no reset: reads are gated by the count.
    always_ff @(posedge clk) begin
        for (int j = 0; j < N_PORTS; j++) begin
            if (push[j]) begin
                mem_data_q[j][wp_q[j]] <= data_in[gnt_idx[j]*DATA_W +: DATA_W];
                mem_src_q[j][wp_q[j]]  <= gnt_idx[j];
            end
        end
    end

    always_comb begin
        data_out = '0;
        addr_out = '0;
        data_rdy = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            data_rdy[j] = (cnt_q[j] != '0);
            if (data_rdy[j]) begin
                data_out[j*DATA_W +: DATA_W] = mem_data_q[j][rp_q[j]];
                addr_out[j*ADDR_W +: ADDR_W] = ADDR_W'(mem_src_q[j][rp_q[j]]);
            end
        end
    end

    assign fifo_empty = empty_q;
    assign fifo_full  = full_q;
    assign fifo_ae    = ae_q;
    assign fifo_af    = af_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_xsw_switch_core.sv
// Directed scenarios plus randomized traffic, checked each cycle against a
// queue-based reference of the crossbar (routing, round-robin, FIFOs, drops).
module tb_xsw_switch_core;
    localparam int N  = 8;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int D  = 8;
    localparam int AE = 1;
    localparam int AF = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*AW-1:0]   addr_in, addr_out;
    logic [N*DW-1:0]   data_in, data_out;
    logic [N-1:0]      wr_en, data_rcv, data_rdy, rd_en, port_sel;
    logic [N-1:0]      fifo_empty, fifo_full, fifo_ae, fifo_af;
    logic              port_en, port_wr;
    logic [AW-1:0]     port_addr;
    logic [15:0]       drop_cnt;

    always #5 clk = ~clk;

    xsw_switch_core #(.N_PORTS(N), .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D),
                      .AE_LEVEL(AE), .AF_LEVEL(AF)) dut (
        .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in),
        .wr_en(wr_en), .data_rcv(data_rcv), .addr_out(addr_out), .data_out(data_out),
        .data_rdy(data_rdy), .rd_en(rd_en), .port_en(port_en), .port_wr(port_wr),
        .port_sel(port_sel), .port_addr(port_addr), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_ae(fifo_ae), .fifo_af(fifo_af), .drop_cnt(drop_cnt)
    );

    logic [DW-1:0] qd [N][$];
    int            qs [N][$];
    int            rr [N];
    logic [AW-1:0] ma [N];
    int            mdrop;
    int            checks = 0, errors = 0;
    logic [N-1:0]  last_rcv;
    int            nsent [N];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            qd[j].delete();
            qs[j].delete();
            rr[j] = 0;
            ma[j] = AW'(j);
        end
        mdrop = 0;
    endtask

    task automatic set_in(input int i, input bit en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[i]            = en;
        addr_in[i*AW +: AW] = a;
        data_in[i*DW +: DW] = d;
    endtask

    task automatic idle();
        wr_en = '0; rd_en = '0; port_en = 1'b0; port_wr = 1'b0; port_sel = '0;
    endtask

    // Called just after a negedge with inputs set; checks, then advances the model at the posedge.
    task automatic cycle();
        int tgt [N];
        bit hit [N];
        int gnt [N];
        int miss, sz;
        logic [N-1:0]    e_rcv, e_rdy, e_emp, e_full, e_ae, e_af;
        logic [N*DW-1:0] e_do;
        logic [N*AW-1:0] e_ao;
        #1;
        miss = 0;
        for (int i = 0; i < N; i++) begin
            hit[i] = 0; tgt[i] = 0;
            for (int j = 0; j < N; j++)
                if (!hit[i] && ma[j] == addr_in[i*AW +: AW]) begin hit[i] = 1; tgt[i] = j; end
            if (wr_en[i] && !hit[i]) miss++;
        end
        for (int j = 0; j < N; j++) begin
            gnt[j] = -1;
            if (qd[j].size() < D)
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (rr[j] + k) % N;
                    if (gnt[j] < 0 && wr_en[idx] && hit[idx] && tgt[idx] == j) gnt[j] = idx;
                end
        end
        e_do = '0; e_ao = '0;
        for (int i = 0; i < N; i++) e_rcv[i] = wr_en[i] && (!hit[i] || gnt[tgt[i]] == i);
        for (int j = 0; j < N; j++) begin
            sz = qd[j].size();
            e_rdy[j] = sz > 0; e_emp[j] = sz == 0; e_full[j] = sz == D;
            e_ae[j] = sz <= AE; e_af[j] = sz >= AF;
            if (sz > 0) begin
                e_do[j*DW +: DW] = qd[j][0];
                e_ao[j*AW +: AW] = AW'(qs[j][0]);
            end
        end
        last_rcv = data_rcv;
        chk("data_rcv", data_rcv, e_rcv);
        chk("data_rdy", data_rdy, e_rdy);
        chk("fifo_empty", fifo_empty, e_emp);
        chk("fifo_full", fifo_full, e_full);
        chk("fifo_ae", fifo_ae, e_ae);
        chk("fifo_af", fifo_af, e_af);
        chk("data_out", data_out, e_do);
        chk("addr_out", addr_out, e_ao);
        chk("drop_cnt", drop_cnt, mdrop);
        @(posedge clk);
        for (int j = 0; j < N; j++) begin
            if (rd_en[j] && qd[j].size() > 0) begin
                void'(qd[j].pop_front());
                void'(qs[j].pop_front());
            end
            if (gnt[j] >= 0) begin
                qd[j].push_back(data_in[gnt[j]*DW +: DW]);
                qs[j].push_back(gnt[j]);
                rr[j] = (gnt[j] + 1) % N;
            end
            if (port_en && port_wr && port_sel[j]) ma[j] = port_addr;
        end
        mdrop = (mdrop + miss > 65535) ? 65535 : mdrop + miss;
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_empty"}, fifo_empty, {N{1'b1}});
        chk({tag, "_rdy"}, data_rdy, '0);
        chk({tag, "_full"}, fifo_full, '0);
        chk({tag, "_ae"}, fifo_ae, {N{1'b1}});
        chk({tag, "_af"}, fifo_af, '0);
        chk({tag, "_drop"}, drop_cnt, 0);
        chk({tag, "_dout"}, data_out, '0);
        chk({tag, "_aout"}, addr_out, '0);
    endtask

    logic [DW-1:0] exp_order [6];

    initial begin
        reset = 1'b1; addr_in = '0; data_in = '0; port_addr = '0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_reset_state("rst");
        reset = 1'b0;
        @(negedge clk);

        // Single word to output 3, then pop it.
        set_in(0, 1, 8'd3, 8'hA5);
        cycle();
        chk("t1_rcv", last_rcv[0], 1'b1);
        idle();
        chk("t1_rdy", data_rdy[3], 1'b1);
        chk("t1_dout", data_out[3*DW +: DW], 8'hA5);
        chk("t1_aout", addr_out[3*AW +: AW], 8'h00);
        rd_en[3] = 1'b1;
        cycle();
        idle();
        cycle();
        chk("t1_empty", fifo_empty[3], 1'b1);

        // Three held requesters contend for output 4.
        for (int i = 0; i < N; i++) nsent[i] = 0;
        for (int c = 0; c < 6; c++) begin
            foreach (exp_order[k]) ;
            set_in(1, 1, 8'd4, 8'h10 + DW'(nsent[1]));
            set_in(2, 1, 8'd4, 8'h20 + DW'(nsent[2]));
            set_in(5, 1, 8'd4, 8'h50 + DW'(nsent[5]));
            cycle();
            for (int i = 0; i < N; i++) if (last_rcv[i]) nsent[i]++;
        end
        idle();
        exp_order = '{8'h10, 8'h20, 8'h50, 8'h11, 8'h21, 8'h51};
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t2_order%0d", k), data_out[4*DW +: DW], exp_order[k]);
            rd_en[4] = 1'b1;
            cycle();
        end
        idle();

        // Reprogram output 0 to 0x40; old address 0 now misses.
        port_en = 1'b1; port_wr = 1'b1; port_sel = 8'h01; port_addr = 8'h40;
        cycle();
        idle();
        set_in(2, 1, 8'h40, 8'h77);
        cycle();
        set_in(2, 1, 8'h00, 8'h12);
        cycle();
        chk("t3_drop_rcv", last_rcv[2], 1'b1);
        idle();
        cycle();
        chk("t3_dout0", data_out[0 +: DW], 8'h77);
        chk("t3_drop", drop_cnt, 16'd1);
        rd_en[0] = 1'b1;
        cycle();
        idle();

        // Fill output 6, then hold a ninth word until one pop frees a slot.
        for (int k = 0; k < 8; k++) begin
            set_in(0, 1, 8'd6, 8'h60 + DW'(k));
            cycle();
        end
        set_in(0, 1, 8'd6, 8'h68);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t4_blocked", last_rcv[0], 1'b0);
        end
        chk("t4_full", fifo_full[6], 1'b1);
        chk("t4_af", fifo_af[6], 1'b1);
        rd_en[6] = 1'b1;
        cycle();
        chk("t4_full_pop", last_rcv[0], 1'b0);
        rd_en[6] = 1'b0;
        cycle();
        chk("t4_accept", last_rcv[0], 1'b1);
        idle();
        rd_en[6] = 1'b1;
        repeat (9) cycle();
        idle();

        // Output 2 at count 4: simultaneous push and pop, then pops past empty.
        for (int k = 0; k < 4; k++) begin
            set_in(3, 1, 8'd2, 8'h30 + DW'(k));
            cycle();
        end
        set_in(3, 1, 8'd2, 8'h34);
        rd_en[2] = 1'b1;
        cycle();
        idle();
        chk("t5_dout", data_out[2*DW +: DW], 8'h31);
        rd_en[2] = 1'b1;
        repeat (6) cycle();
        idle();
        chk("t5_empty", fifo_empty[2], 1'b1);

        // Queue 5 words, move output 3's address, then reset mid-burst.
        port_en = 1'b1; port_wr = 1'b1; port_sel = 8'h08; port_addr = 8'h33;
        cycle();
        idle();
        for (int k = 0; k < 5; k++) begin
            set_in(1, 1, 8'd5, 8'h90 + DW'(k));
            cycle();
        end
        idle();
        set_in(4, 1, 8'hEE, 8'h00);
        cycle();
        idle();
        #2 reset = 1'b1;
        #1 model_reset();
        check_reset_state("rst2");
        @(negedge clk);
        reset = 1'b0;
        set_in(0, 1, 8'd3, 8'hC3);
        cycle();
        idle();
        chk("t6_addr3", data_out[3*DW +: DW], 8'hC3);
        cycle();

        // Randomized traffic honouring hold-until-accept.
        last_rcv = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!wr_en[i] || last_rcv[i]) begin
                    if ($urandom_range(0, 3) != 0)
                        set_in(i, 1, AW'($urandom_range(0, 9)), DW'($urandom));
                    else
                        wr_en[i] = 1'b0;
                end
            end
            for (int j = 0; j < N; j++)
                rd_en[j] = (c < 250) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            port_en = ($urandom_range(0, 24) == 0);
            port_wr = $urandom_range(0, 1);
            port_sel = N'($urandom);
            port_addr = AW'($urandom_range(0, 9));
            cycle();
        end
        idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
